// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: widths, queue entry layout and
// the thermometer encoding decode uses to pop instructions.
package fetch_unit_pkg;

  localparam int ADDR_W      = 10;
  localparam int INSTR_W     = 32;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Thermometer pop encodings from decode; 2'b10 is never legal.
  localparam logic [1:0] TAKE_NONE = 2'b00;
  localparam logic [1:0] TAKE_ONE  = 2'b01;
  localparam logic [1:0] TAKE_TWO  = 2'b11;

  // Number of entries popped for a take code; the illegal code pops nothing.
  function automatic logic [1:0] take_count(input logic [1:0] take);
    case (take)
      TAKE_ONE: return 2'd1;
      TAKE_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue: writes a fetched pair per push, exposes the
// two oldest entries, pops 0..2 per cycle and flushes to empty in one edge.
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr0,
  input  logic [INSTR_W-1:0] push_instr1,
  input  logic [PC_W-1:0]    push_pc0,
  input  logic [PC_W-1:0]    push_pc1,
  input  logic [1:0]         pop_n,
  output logic [INSTR_W-1:0] head_instr0,
  output logic [INSTR_W-1:0] head_instr1,
  output logic [PC_W-1:0]    head_pc0,
  output logic [PC_W-1:0]    head_pc1,
  output logic [CNT_W-1:0]   count
);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   head_nxt1;
  logic [PTR_W-1:0]   tail_nxt1;

  // Second read/write port addresses; wrap is implicit in the pointer width.
  always_comb begin
    head_nxt1 = head + PTR_W'(1);
    tail_nxt1 = tail + PTR_W'(1);
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[tail]      <= push_instr0;
      pc_mem[tail]         <= push_pc0;
      instr_mem[tail_nxt1] <= push_instr1;
      pc_mem[tail_nxt1]    <= push_pc1;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(2);
      head  <= head + PTR_W'(pop_n);
      count <= count + (push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n);
    end
  end

  // Oldest two entries, always presented; the top masks invalid slots.
  always_comb begin
    head_instr0 = instr_mem[head];
    head_pc0    = pc_mem[head];
    head_instr1 = instr_mem[head_nxt1];
    head_pc1    = pc_mem[head_nxt1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the fetch PC, drives the synchronous imem,
// captures each returned instruction pair into the queue and hands up to
// two instructions per cycle to decode. A redirect flushes everything and
// fetches the target in the same cycle.
module fetch_unit #(
  parameter int                QUEUE_DEPTH = 8,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  output logic [ADDR_W-1:0]            imem_address_o,
  output logic                         imem_stall_o,
  input  logic [63:0]                  imem_data_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_target_i,
  output logic [1:0]                   dec_valid_o,
  output logic [31:0]                  dec_instr0_o,
  output logic [31:0]                  dec_instr1_o,
  output logic [ADDR_W-1:0]            dec_pc0_o,
  output logic [ADDR_W-1:0]            dec_pc1_o,
  input  logic [1:0]                   dec_take_i,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count_o
);
  import fetch_unit_pkg::*;

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  // Highest occupancy at which a new fetch is still safe. With a pair in
  // flight, room is needed for it plus the pair being requested now.
  localparam logic [CNT_W-1:0] MAX_CNT_INFLIGHT = CNT_W'(QUEUE_DEPTH - 2 * FETCH_WIDTH);
  localparam logic [CNT_W-1:0] MAX_CNT_IDLE     = CNT_W'(QUEUE_DEPTH - FETCH_WIDTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight_valid;
  logic               fetch_en;
  logic               enq;
  logic [1:0]         pop_n;
  logic [1:0]         slot_valid;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] head_instr0;
  logic [INSTR_W-1:0] head_instr1;
  logic [ADDR_W-1:0]  head_pc0;
  logic [ADDR_W-1:0]  head_pc1;

  // Fetch/stall decision and decode-side gating; redirect overrides all.
  always_comb begin
    fetch_en       = redirect_i ||
                     (count <= (inflight_valid ? MAX_CNT_INFLIGHT : MAX_CNT_IDLE));
    imem_stall_o   = !fetch_en;
    imem_address_o = redirect_i ? redirect_target_i : fetch_pc;
    enq            = inflight_valid && !redirect_i;
    pop_n          = redirect_i ? 2'd0 : take_count(dec_take_i);
    slot_valid     = redirect_i ? 2'b00 : {count >= CNT_W'(2), count >= CNT_W'(1)};
  end

  // Fetch PC and tracking of the pair imem returns on the next cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_pc       <= RESET_PC;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
    end else if (fetch_en) begin
      inflight_pc    <= imem_address_o;
      inflight_valid <= 1'b1;
      fetch_pc       <= imem_address_o + ADDR_W'(FETCH_WIDTH);
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  fetch_unit_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PC_W  (ADDR_W)
  ) u_queue (
    .clk         (clock_i),
    .rst_n       (reset_n_i),
    .flush       (redirect_i),
    .push        (enq),
    .push_instr0 (imem_data_i[31:0]),
    .push_instr1 (imem_data_i[63:32]),
    .push_pc0    (inflight_pc),
    .push_pc1    (inflight_pc + ADDR_W'(1)),
    .pop_n       (pop_n),
    .head_instr0 (head_instr0),
    .head_instr1 (head_instr1),
    .head_pc0    (head_pc0),
    .head_pc1    (head_pc1),
    .count       (count)
  );

  // Decode slots read as zero whenever they are not valid.
  always_comb begin
    dec_valid_o   = slot_valid;
    dec_instr0_o  = slot_valid[0] ? head_instr0 : '0;
    dec_pc0_o     = slot_valid[0] ? head_pc0    : '0;
    dec_instr1_o  = slot_valid[1] ? head_instr1 : '0;
    dec_pc1_o     = slot_valid[1] ? head_pc1    : '0;
    queue_count_o = count;
  end

endmodule
